stream_xbar_arbiter: RTL and testbench

- Per-master-port packet arbiter for stream_xbar; one instance per master output.
- Chooses which slave input owns the master port, round-robin between inputs.
- Holds that choice for a whole packet, until the beat with last=1 is accepted.
- Drives the crossbar mux select (grant_id_o) and the per-source ready gating (grant_o).

---
 rtl/stream_xbar_arbiter_pkg.sv | 11 +
 rtl/stream_xbar_arbiter_if.sv | 17 +
 rtl/stream_xbar_arbiter_rr_pick.sv | 30 +++
 rtl/stream_xbar_arbiter.sv | 103 ++++++++++
 tb/tb_stream_xbar_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/stream_xbar_arbiter_pkg.sv
// Shared types for stream_xbar and its per-master-port arbiter.
package stream_xbar_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  // Select width for n sources; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_xbar_arbiter_if.sv
// Arbiter handshake bundle: requests/last/ready in, grant/select/busy out.
interface stream_xbar_arbiter_if #(
  parameter int S_DATA_COUNT = 2,
  parameter int ID_WIDTH     = 1
) ();
  logic [S_DATA_COUNT-1:0] req_i;
  logic [S_DATA_COUNT-1:0] last_i;
  logic                    ready_i;
  logic [S_DATA_COUNT-1:0] grant_o;
  logic [ID_WIDTH-1:0]     grant_id_o;
  logic                    busy_o;

  // Arbiter side.
  modport slave  (input  req_i, last_i, ready_i, output grant_o, grant_id_o, busy_o);
  // Crossbar side.
  modport master (output req_i, last_i, ready_i, input  grant_o, grant_id_o, busy_o);
endinterface

// File: rtl/stream_xbar_arbiter_rr_pick.sv
// Round-robin pick: first set bit of (req & ~mask) at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [N-1:0] eff;

  assign eff = req & ~mask;

  // Walk the rotated request vector from ptr; the first hit is unrotated into idx.
  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && eff[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/stream_xbar_arbiter.sv
// Per-master-port packet arbiter for stream_xbar: round-robin between
// sources, grant held for a whole packet (until the last beat is accepted).
// Optional packet counters when STREAM_XBAR_ARB_PERF_EN is defined.
module stream_xbar_arbiter
  import stream_xbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int ID_WIDTH     = id_width(S_DATA_COUNT),
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef STREAM_XBAR_ARB_PERF_EN
  input  logic                              cnt_clr_i,
  output logic [S_DATA_COUNT*CNT_WIDTH-1:0] pkt_cnt_o,
`endif
  stream_xbar_arbiter_if.slave arb
);
  if (S_DATA_COUNT < 2 || CNT_WIDTH < 1) begin : g_bad_cfg
    $error("stream_xbar_arbiter: needs S_DATA_COUNT >= 2 and CNT_WIDTH >= 1");
  end

  arb_state_e              state_q, state_d;
  logic [S_DATA_COUNT-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0]     gid_q, gid_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [S_DATA_COUNT-1:0] pick_mask;
  logic [ID_WIDTH-1:0]     pick_idx, ptr_nxt;
  logic                    pick_found, acc, eop;

  assign acc = (state_q == BUSY) & arb.req_i[gid_q] & arb.ready_i;
  assign eop = acc & arb.last_i[gid_q];

  // At end of packet the owner's request belongs to the beat just consumed,
  // so it is masked; the owner can only come back through the IDLE pick.
  assign pick_mask = (state_q == BUSY) ? grant_q : '0;

  rr_pick #(.N(S_DATA_COUNT), .IW(ID_WIDTH)) u_pick (
    .req   (arb.req_i),
    .ptr   (ptr_q),
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign ptr_nxt = (pick_idx == ID_WIDTH'(S_DATA_COUNT - 1)) ? '0 : pick_idx + 1'b1;

  // Next state: arbitrate when idle or on eop; winner becomes lowest priority.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE || eop) begin
      if (pick_found) begin
        state_d = BUSY;
        grant_d = S_DATA_COUNT'(1) << pick_idx;
        gid_d   = pick_idx;
        ptr_d   = ptr_nxt;
      end else if (state_q == BUSY) begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  // State registers; reset drops ownership immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign arb.grant_o    = grant_q;
  assign arb.grant_id_o = gid_q;
  assign arb.busy_o     = (state_q == BUSY);

`ifdef STREAM_XBAR_ARB_PERF_EN
  logic [S_DATA_COUNT-1:0][CNT_WIDTH-1:0] cnt_q;

  for (genvar k = 0; k < S_DATA_COUNT; k++) begin : g_cnt
    // Saturating per-source packet counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q[k] <= '0;
      else if (cnt_clr_i)
        cnt_q[k] <= '0;
      else if (eop && gid_q == ID_WIDTH'(k) && !(&cnt_q[k]))
        cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  assign pkt_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// Bench for stream_xbar_arbiter: a 2-source instance driven from a vector
// table plus hand-written corner sequences, and a 4-source instance for
// round-robin fairness (and packet counters when the perf macro is set).
module tb_stream_xbar_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cnt_clr2, cnt_clr4;
  logic [31:0] cnt2;
  logic [63:0] cnt4;

  stream_xbar_arbiter_if #(.S_DATA_COUNT(2), .ID_WIDTH(1)) if2 ();
  stream_xbar_arbiter_if #(.S_DATA_COUNT(4), .ID_WIDTH(2)) if4 ();

  stream_xbar_arbiter #(.S_DATA_COUNT(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef STREAM_XBAR_ARB_PERF_EN
    .cnt_clr_i (cnt_clr2),
    .pkt_cnt_o (cnt2),
`endif
    .arb       (if2)
  );

  stream_xbar_arbiter #(.S_DATA_COUNT(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef STREAM_XBAR_ARB_PERF_EN
    .cnt_clr_i (cnt_clr4),
    .pkt_cnt_o (cnt4),
`endif
    .arb       (if4)
  );

  typedef struct {
    logic [1:0] req, last;
    logic       rdy;
    logic [1:0] g;
    logic       id;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
  } exp_t;

  vec_t v[20];
  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    cnt_clr2 = 1'b0; cnt_clr4 = 1'b0;
    if2.req_i = '0; if2.last_i = '0; if2.ready_i = 1'b1;
    if4.req_i = '0; if4.last_i = '0; if4.ready_i = 1'b1;

    //            req    last   rdy   grant  id    busy
    v[0]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0}; // idle, no request
    v[1]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1}; // contention: 0 wins
    v[2]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1}; // beat 1
    v[3]  = '{2'b11, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1}; // last -> 1, no bubble
    v[4]  = '{2'b11, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1}; // single beat of 1 -> 0
    v[5]  = '{2'b11, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1}; // backpressure x5, last ignored
    v[6]  = '{2'b11, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    v[7]  = '{2'b11, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    v[8]  = '{2'b11, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    v[9]  = '{2'b11, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1};
    v[10] = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1}; // mid beat accepted
    v[11] = '{2'b11, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1}; // last accepted -> 1
    v[12] = '{2'b00, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1}; // owner drops req: hold
    v[13] = '{2'b10, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0}; // eop, none else -> IDLE, id held
    v[14] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0}; // stays idle
    v[15] = '{2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1}; // single-beat request
    v[16] = '{2'b10, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0}; // granted exactly 1 cycle
    v[17] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    v[18] = '{2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1}; // 0 single beat
    v[19] = '{2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};

    // Reset state while rst_n is held low.
    #12;
    chk("reset2", {if2.grant_o, if2.grant_id_o, if2.busy_o}, 4'b0000);
    chk("reset4", {if4.grant_o, if4.grant_id_o, if4.busy_o}, 7'b0000000);
    @(negedge clk) rst_n = 1'b1;

    // Vector table on the 2-source instance.
    for (int i = 0; i < 20; i++) begin
      if2.req_i = v[i].req; if2.last_i = v[i].last; if2.ready_i = v[i].rdy;
      sb.push_back('{{2'b00, v[i].g}, {1'b0, v[i].id}, v[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), {if2.grant_o, if2.grant_id_o, if2.busy_o},
          {e.g[1:0], e.id[0], e.busy});
    end

    // Reset mid-packet while source 1 owns the port.
    if2.req_i = 2'b10; if2.last_i = 2'b00; if2.ready_i = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_owner1", {if2.grant_o, if2.grant_id_o, if2.busy_o}, 4'b1011);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {if2.grant_o, if2.grant_id_o, if2.busy_o}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    if2.req_i = 2'b11;
    @(posedge clk); #1;
    chk("post_rst_pick0", {if2.grant_o, if2.grant_id_o, if2.busy_o}, 4'b0101);
    if2.req_i = 2'b00;

    // Fairness: 4 sources always requesting single-beat packets.
    if4.req_i = 4'b1111; if4.last_i = 4'b1111; if4.ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sb.push_back('{4'b0001 << (i % 4), 2'(i % 4), 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("fair%0d", i), {if4.grant_o, if4.grant_id_o, if4.busy_o},
          {e.g, e.id, e.busy});
    end
    // Accept the 12th packet (owner 3), then starve so owner 0 just holds.
    @(posedge clk); #1;
    if4.req_i = 4'b0000;
    chk("fair_wrap", {if4.grant_o, if4.grant_id_o, if4.busy_o}, 7'b0001001);

`ifdef STREAM_XBAR_ARB_PERF_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("cnt%0d", k), cnt4[k*16 +: 16], 16'd3);
    // Clear together with an eop: clear wins.
    if4.req_i = 4'b0001; if4.last_i = 4'b0001; cnt_clr4 = 1'b1;
    @(posedge clk); #1;
    cnt_clr4 = 1'b0; if4.req_i = 4'b0000;
    for (int k = 0; k < 4; k++)
      chk($sformatf("clr%0d", k), cnt4[k*16 +: 16], 16'd0);
    chk("clr_idle", {if4.grant_o, if4.busy_o}, 5'b00000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
